// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int BTN_CLR   = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_LAP   = 2;
  localparam int BTN_START = 3;

  localparam int TICK_DIV_DEF   = 1200000;
  localparam int DEB_CYCLES_DEF = 120000;
  localparam int LAP_HOLD_DEF   = 20;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn.sv
// Button conditioner: 2-flop synchroniser, stability counter, rise-edge press pulse.
// Press pulse appears 2 + DEB_CYCLES + 1 cycles after a clean raw edge.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      press   <= level & ~level_q;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, run/stop/idle FSM, 0.1 s tick, lap hold.
// Commands act on the edge that samples the press pulse; all strobes are registered.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int LAP_HOLD   = LAP_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_i,
  input  logic [7:0] count_i,
  output logic       count_inc_o,
  output logic       count_clr_o,
  output logic [7:0] lap_value_o,
  output logic       disp_sel_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int LW = $clog2(LAP_HOLD + 1);
  localparam logic [LW-1:0] LAP_LOAD = LW'(LAP_HOLD);

  logic [3:0]    press;
  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [LW-1:0] lap_timer;
  logic          clr_p, stop_p, lap_p, start_p;
  logic          tick, restart;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_i[i]),
      .press (press[i])
    );
  end

  assign clr_p   = press[BTN_CLR];
  assign stop_p  = press[BTN_STOP];
  assign lap_p   = press[BTN_LAP];
  assign start_p = press[BTN_START];

  // Divider only advances in RUN, so STOP freezes the phase for a seamless resume.
  assign tick    = (state == RUN) && (tick_cnt == TICK_LAST);
  assign restart = clr_p | (start_p & ~stop_p & (state == IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      lap_timer   <= '0;
      count_inc_o <= 1'b0;
      count_clr_o <= 1'b0;
      lap_value_o <= 8'h00;
    end else begin
      count_inc_o <= tick & ~clr_p;
      count_clr_o <= clr_p;

      if (restart)
        tick_cnt <= '0;
      else if (state == RUN)
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (clr_p)
        state <= IDLE;
      else if (stop_p) begin
        if (state == RUN)
          state <= STOP;
      end else if (start_p && state != RUN)
        state <= RUN;

      // count_i still holds the pre-increment value when a tick coincides.
      if (clr_p)
        lap_timer <= '0;
      else if (lap_p && state != IDLE) begin
        lap_value_o <= count_i;
        lap_timer   <= LAP_LOAD;
      end else if (tick && lap_timer != '0)
        lap_timer <= lap_timer - 1'b1;
    end
  end

  assign disp_sel_o = (lap_timer != '0);
  assign running_o  = (state == RUN);
  assign state_o    = state;

endmodule
